// File: rtl/logic_unit_seq.sv
// logic_unit_seq
// Multi-cycle bitwise logic unit for the MiniMIPS datapath. Operands and
// opcode are captured on start, the result is assembled LANE bits per
// cycle, and the finished word is published in R together with a zero
// flag and a one-cycle done pulse.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-high reset
//   start  - request, sampled only in IDLE or DONE
//   op     - 00 AND, 01 OR, 10 XOR, 11 NOR
//   A, B   - WIDTH-bit operands
//   busy   - high while the result is being assembled
//   done   - one-cycle pulse when R holds a fresh result
//   R      - registered result, holds the last completed value
//   zero   - registered flag, 1 when R == 0
module logic_unit_seq #(
  parameter int WIDTH = 16,
  parameter int LANE  = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] R,
  output logic             zero
);

  localparam int N  = WIDTH / LANE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    k;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] full_res;
  logic             load;
  logic             step;
  logic             last;

  assign last = (k == CW'(N - 1));
  assign busy = (state == RUN);
  assign done = (state == DONE);

  // Bitwise result over the captured operands; only the current lane of it
  // is copied into the accumulator each cycle.
  always_comb begin
    full_res = '0;
    case (op_q)
      2'b00:   full_res = a_q & b_q;
      2'b01:   full_res = a_q | b_q;
      2'b10:   full_res = a_q ^ b_q;
      default: full_res = ~(a_q | b_q);
    endcase
  end

  always_comb begin
    acc_next = acc;
    acc_next[k*LANE +: LANE] = full_res[k*LANE +: LANE];
  end

  // Next-state logic. DONE accepts a new start directly so back-to-back
  // requests skip IDLE.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath. R and zero are written only from the fully assembled word on
  // the last RUN cycle, so they never show a partial result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k    <= '0;
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 2'b00;
      acc  <= '0;
      R    <= '0;
      zero <= 1'b1;
    end else if (load) begin
      a_q  <= A;
      b_q  <= B;
      op_q <= op;
      acc  <= '0;
      k    <= '0;
    end else if (step) begin
      acc <= acc_next;
      if (last) begin
        R    <= acc_next;
        zero <= (acc_next == '0);
        k    <= '0;
      end else begin
        k <= k + 1'b1;
      end
    end
  end

endmodule

// File: doc/logic_unit_seq.md
# logic_unit_seq

Parametrised, multi-cycle bitwise logic unit for the MiniMIPS datapath, generalising the fixed 16-bit OR array to any width and four operations. Operands and opcode are captured on `start`. The result is built LANE bits per cycle and published with a one-cycle `done` pulse and a zero flag. It sits beside the ALU and serves logical instructions (AND/OR/XOR/NOR) through a start/busy/done handshake.

## Interface
- `WIDTH`, default 16: operand/result width in bits.
- `LANE`, default 4: bits processed per cycle. WIDTH must be a multiple of LANE, and LANE must be at least 1. N = WIDTH/LANE.
- `clk`  in  1  clock. All state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  request. Sampled only in IDLE or DONE.
- `op`  in  2  operation: 00 AND, 01 OR, 10 XOR, 11 NOR.
- `A`  in  WIDTH  operand A.
- `B`  in  WIDTH  operand B.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse, high in the DONE state.
- `R`  out  WIDTH  registered result. Holds the last completed result.
- `zero`  out  1  registered; 1 when R == 0.

## Operation
- FSM states: IDLE, RUN, DONE.
- **IDLE**
  - `start`=1: capture A, B, op into internal registers; clear the accumulator; chunk counter k=0; go to RUN.
  - Otherwise stay in IDLE.
- **RUN**
  - Each cycle, write accumulator bits [k*LANE +: LANE] = op applied to captured A and B chunk k; k increments.
  - When k = N-1: write the final chunk and load R. Set `zero` = (full result == 0). Go to DONE.
- **DONE**
  - `done`=1 for exactly this cycle.
  - `start`=1: capture new operands as in IDLE and go directly to RUN (back-to-back).
  - Otherwise go to IDLE.
- `start` asserted during RUN is ignored. It is neither queued nor able to abort the current operation.
- Changes to A, B or op after the capture edge do not affect the result.
- R and `zero` change only at the edge leaving the last RUN cycle. They are never partially updated, and hold their value in IDLE and DONE.
- NOR is the bitwise complement of OR over the full width. No width extension or truncation applies; all operations are purely bitwise.
- Counter width is ceil(log2(N)) bits, minimum 1. No wrap occurs beyond N-1.

## Timing
- Reset (asynchronous, immediate, any state, including mid-RUN):
  - state=IDLE, k=0, accumulator=0.
  - `busy`=0, `done`=0, R=0, `zero`=1.
  - An in-flight operation is discarded and produces no `done`.
- Latency:
  - `start` sampled at edge T.
  - `busy`=1 from T through edge T+N.
  - R, `zero` and `done` become valid after edge T+N.
  - `done` falls after edge T+N+1.
- Throughput: with `start` held high in DONE, one result every N+1 cycles.
- N=1 (LANE=WIDTH): one RUN cycle, then DONE. Latency is one cycle.
- `busy` and `done` are never high together.

## Test plan
1. **OR**, WIDTH=16, LANE=4, A=0x00F0, B=0x0F0F, pulse `start` -> `busy` for 4 cycles, then R=0x0FFF, `zero`=0, `done` high exactly 1 cycle.
2. **AND/XOR/NOR**:
   - AND 0xF0F0, 0x0F0F -> R=0x0000, `zero`=1.
   - XOR 0xAAAA, 0xFFFF -> 0x5555.
   - NOR 0x0000, 0x0000 -> 0xFFFF, `zero`=0.
3. **Capture isolation**: start OR A=0x1234, B=0x0000; during RUN drive A=0xFFFF, op=AND, and pulse `start` -> result still 0x1234, only one `done`.
4. **Back-to-back**: hold `start` high through DONE with new operands XOR 0x00FF, 0x0F0F -> second RUN begins immediately, R=0x0FF0 after 4 more cycles, second `done` 5 cycles after the first.
5. **Reset mid-operation**: assert `reset` in the 2nd RUN cycle -> `busy`=0, R=0, `zero`=1 immediately; no `done`. After release, a new OR 0x8000, 0x0001 completes with 0x8001.
6. **Parameter sweep**:
   - WIDTH=32, LANE=32: OR 0xFFFF0000, 0x0000FFFF -> 0xFFFFFFFF after 1 RUN cycle.
   - WIDTH=8, LANE=1: AND 0xC3, 0x81 -> 0x81 after 8 cycles.
